relu_maxpool: RTL and testbench

Post-convolution stage: consumes the scalar result stream of the convolution MAC unit, one `result` per `done` pulse, in raster order over an `IMG_W x IMG_H` feature map. Applies ReLU, then 2x2 stride-2 max pooling, using a half-row buffer of partial maxima. Emits one pooled value per 2x2 window to the next layer (flatten / dense stage).

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/pool_line_buf.sv | 33 +++
 rtl/relu_maxpool.sv | 163 ++++++++++++++++
 tb/tb_relu_maxpool.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: pooling geometry, MNIST conv output size, pool FSM
// states and a signed max helper used by the post-convolution stages.
package cnn_pkg;

   localparam int POOL_SIZE    = 2;
   localparam int MNIST_CONV_W = 26;
   localparam int MNIST_CONV_H = 26;

   // Widest operand max2 handles; callers sign-extend into it and truncate back.
   localparam int MAX2_W = 64;

   typedef enum logic [1:0] {
      S_EVEN = 2'd0,
      S_ODD  = 2'd1,
      S_DROP = 2'd2
   } pool_state_e;

   function automatic logic signed [MAX2_W-1:0] max2(
      input logic signed [MAX2_W-1:0] a,
      input logic signed [MAX2_W-1:0] b
   );
      return (a >= b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer of vertical-pair partial maxima: one synchronous write port,
// one combinational read port, asynchronous active-low clear.
module pool_line_buf #(
   parameter int WIDTH  = 25,
   parameter int DEPTH  = 13,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the storage array is cleared on reset because it must come up as
   // zeros; that makes it flops rather than a RAM macro, fine at this depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-ordered result stream.
// Build option RELU_MAXPOOL_RELU_EN: defined applies ReLU, undefined passes data raw.
module relu_maxpool
   import cnn_pkg::*;
#(
   parameter int INWIDTH = 25,
   parameter int IMG_W   = MNIST_CONV_W,
   parameter int IMG_H   = MNIST_CONV_H,
   parameter int COL_BIT = 5,
   parameter int ROW_BIT = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   input  logic [INWIDTH-1:0] in_data,
   output logic               out_valid,
   output logic [INWIDTH-1:0] out_data,
   output logic               frame_done
);

   localparam int BUF_DEPTH = IMG_W / POOL_SIZE;
   localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [COL_BIT-1:0] LAST_COL = COL_BIT'(IMG_W - 1);
   localparam logic [ROW_BIT-1:0] LAST_ROW = ROW_BIT'(IMG_H - 1);
   localparam logic [ROW_BIT-1:0] PRE_LAST_ROW = ROW_BIT'(IMG_H - 2);
   localparam bit ODD_W = (IMG_W % 2) != 0;
   localparam bit ODD_H = (IMG_H % 2) != 0;

   pool_state_e        state_q, state_d;
   logic [COL_BIT-1:0] col_q, col_d;
   logic [ROW_BIT-1:0] row_q, row_d;
   logic [INWIDTH-1:0] pair_q, pair_d;
   logic               out_valid_q, out_valid_d;
   logic [INWIDTH-1:0] out_data_q, out_data_d;
   logic               frame_done_q, frame_done_d;

   logic [INWIDTH-1:0] r_val;
   logic [INWIDTH-1:0] pm;
   logic [INWIDTH-1:0] buf_rd;
   logic [BUF_AW-1:0]  buf_addr;
   logic               buf_we;
   logic               last_col;
   logic               last_row;
   logic               odd_col;
   logic               skip_col;

   function automatic logic [INWIDTH-1:0] smax(
      input logic [INWIDTH-1:0] a,
      input logic [INWIDTH-1:0] b
   );
      return INWIDTH'(max2(MAX2_W'(signed'(a)), MAX2_W'(signed'(b))));
   endfunction

`ifdef RELU_MAXPOOL_RELU_EN
   assign r_val = in_data[INWIDTH-1] ? '0 : in_data;
`else
   assign r_val = in_data;
`endif

   assign last_col = (col_q == LAST_COL);
   assign last_row = (row_q == LAST_ROW);
   assign odd_col  = col_q[0];
   // With an odd width the final (even-indexed) column has no partner.
   assign skip_col = ODD_W && last_col;
   assign pm       = smax(pair_q, r_val);
   assign buf_addr = BUF_AW'(col_q >> 1);

   pool_line_buf #(
      .WIDTH  (INWIDTH),
      .DEPTH  (BUF_DEPTH),
      .ADDR_W (BUF_AW)
   ) u_line_buf (
      .clk       (clk),
      .rst_n     (reset),
      .wr_en_i   (buf_we),
      .wr_addr_i (buf_addr),
      .wr_data_i (pm),
      .rd_addr_i (buf_addr),
      .rd_data_o (buf_rd)
   );

   // NOTE: every signal written here gets a default first so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      pair_d       = pair_q;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      frame_done_d = 1'b0;
      buf_we       = 1'b0;

      if (!start) begin
         state_d    = S_EVEN;
         col_d      = '0;
         row_d      = '0;
         pair_d     = '0;
         out_data_d = '0;
      end else if (in_valid) begin
         if (!odd_col && !skip_col) begin
            pair_d = r_val;
         end

         if (odd_col) begin
            unique case (state_q)
               S_EVEN:  buf_we = 1'b1;
               S_ODD: begin
                  out_valid_d = 1'b1;
                  out_data_d  = smax(pm, buf_rd);
               end
               default: ;
            endcase
         end

         if (last_col) begin
            col_d = '0;
            if (last_row) begin
               row_d        = '0;
               state_d      = S_EVEN;
               frame_done_d = 1'b1;
            end else begin
               row_d = row_q + 1'b1;
               unique case (state_q)
                  S_EVEN:  state_d = S_ODD;
                  S_ODD:   state_d = (ODD_H && (row_q == PRE_LAST_ROW)) ? S_DROP : S_EVEN;
                  default: state_d = S_EVEN;
               endcase
            end
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_EVEN;
         col_q        <= '0;
         row_q        <= '0;
         pair_q       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         pair_q       <= pair_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool: three instances (4x4, 5x5, 26x26) driven
// with directed frames; a negedge monitor pops expected values and cycle stamps.
module tb_relu_maxpool;

   localparam int W = 25;

`ifdef RELU_MAXPOOL_RELU_EN
   localparam bit RELU_ON = 1'b1;
`else
   localparam bit RELU_ON = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] data;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start_s [3];
   logic         vld     [3];
   logic [W-1:0] din     [3];
   logic         ov      [3];
   logic [W-1:0] od      [3];
   logic         fd      [3];

   exp_t exp_q [3][$];
   int   fd_q  [3][$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   int HITS4 [4] = '{5, 7, 13, 15};
   int HITS5 [4] = '{6, 8, 16, 18};
   int VALS5 [4] = '{11, 13, 31, 33};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   relu_maxpool #(.INWIDTH(W), .IMG_W(4), .IMG_H(4), .COL_BIT(2), .ROW_BIT(2)) u4 (
      .clk(clk), .reset(reset), .start(start_s[0]), .in_valid(vld[0]), .in_data(din[0]),
      .out_valid(ov[0]), .out_data(od[0]), .frame_done(fd[0]));

   relu_maxpool #(.INWIDTH(W), .IMG_W(5), .IMG_H(5), .COL_BIT(3), .ROW_BIT(3)) u5 (
      .clk(clk), .reset(reset), .start(start_s[1]), .in_valid(vld[1]), .in_data(din[1]),
      .out_valid(ov[1]), .out_data(od[1]), .frame_done(fd[1]));

   relu_maxpool #(.INWIDTH(W)) u26 (
      .clk(clk), .reset(reset), .start(start_s[2]), .in_valid(vld[2]), .in_data(din[2]),
      .out_valid(ov[2]), .out_data(od[2]), .frame_done(fd[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one pixel and register what the DUT must answer one cycle later.
   task automatic pix(input int k, input logic [W-1:0] d, input bit exp_out,
                      input logic [W-1:0] exp_d, input bit exp_fd);
      exp_t e;
      @(negedge clk);
      vld[k] = 1'b1;
      din[k] = d;
      if (exp_out) begin
         e.data = exp_d;
         e.cyc  = cyc + 1;
         exp_q[k].push_back(e);
      end
      if (exp_fd) fd_q[k].push_back(cyc + 1);
   endtask

   task automatic idle(input int k, input int n);
      repeat (n) begin
         @(negedge clk);
         vld[k] = 1'b0;
      end
   endtask

   task automatic frame4(input int base, input int gap);
      bit hit;
      for (int i = 0; i < 16; i++) begin
         hit = 1'b0;
         foreach (HITS4[j]) if (HITS4[j] == i) hit = 1'b1;
         pix(0, W'(base + i), hit, W'(base + i), i == 15);
         if (gap > 0) idle(0, gap);
      end
      idle(0, 2);
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   c;
      for (int k = 0; k < 3; k++) begin
         if (ov[k]) begin
            check($sformatf("out_valid expected dut%0d", k), 32'(exp_q[k].size() != 0), 32'd1);
            if (exp_q[k].size() != 0) begin
               e = exp_q[k].pop_front();
               check($sformatf("out_data dut%0d", k), 32'(od[k]), 32'(e.data));
               check($sformatf("out latency dut%0d", k), 32'(cyc), 32'(e.cyc));
            end
         end
         if (fd[k]) begin
            check($sformatf("frame_done expected dut%0d", k), 32'(fd_q[k].size() != 0), 32'd1);
            if (fd_q[k].size() != 0) begin
               c = fd_q[k].pop_front();
               check($sformatf("frame_done cycle dut%0d", k), 32'(cyc), 32'(c));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      logic [W-1:0] neg3;
      logic [W-1:0] exp26;
      neg3  = -25'sd3;
      exp26 = RELU_ON ? '0 : neg3;

      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_s[k] = 1'b0;
         vld[k]     = 1'b0;
         din[k]     = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset out_valid dut%0d", k), 32'(ov[k]), 32'd0);
         check($sformatf("reset out_data dut%0d", k), 32'(od[k]), 32'd0);
         check($sformatf("reset frame_done dut%0d", k), 32'(fd[k]), 32'd0);
      end
      reset = 1'b1;
      for (int k = 0; k < 3; k++) start_s[k] = 1'b1;

      // 4x4 ramp back-to-back, then with 3 idle cycles between pixels.
      frame4(0, 0);
      frame4(0, 3);

      // 5x5: value row*10+col; column 4 and row 4 produce nothing.
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            bit hit;
            logic [W-1:0] v;
            hit = 1'b0;
            v   = '0;
            foreach (HITS5[j]) if (HITS5[j] == r * 5 + c) begin
               hit = 1'b1;
               v   = W'(VALS5[j]);
            end
            pix(1, W'(r * 10 + c), hit, v, (r == 4) && (c == 4));
         end
      end
      idle(1, 3);

      // Full 26x26 frame of -3.
      for (int r = 0; r < 26; r++) begin
         for (int c = 0; c < 26; c++) begin
            pix(2, neg3, (r % 2 == 1) && (c % 2 == 1), exp26, (r == 25) && (c == 25));
         end
      end
      idle(2, 3);

      // Abort after pixel (2,1): rows 0-1 windows are complete, row 2 is not.
      for (int i = 0; i < 10; i++) begin
         pix(0, W'(50 + i), (i == 5) || (i == 7), W'(50 + i), 1'b0);
      end
      @(negedge clk);
      vld[0]     = 1'b0;
      start_s[0] = 1'b0;
      @(negedge clk);
      vld[0] = 1'b1;
      din[0] = W'(999);
      @(negedge clk);
      vld[0] = 1'b0;
      check("abort out_data", 32'(od[0]), 32'd0);
      check("abort out_valid", 32'(ov[0]), 32'd0);
      check("abort frame_done", 32'(fd[0]), 32'd0);
      start_s[0] = 1'b1;
      frame4(100, 0);

      // Async reset while out_valid is high, between clock edges.
      for (int i = 0; i < 8; i++) begin
         pix(0, W'(200 + i), (i == 5) || (i == 7), W'(200 + i), 1'b0);
      end
      @(negedge clk);
      vld[0] = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("async reset out_valid", 32'(ov[0]), 32'd0);
      check("async reset out_data", 32'(od[0]), 32'd0);
      check("async reset frame_done", 32'(fd[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      frame4(300, 0);
      idle(0, 4);

      for (int k = 0; k < 3; k++) begin
         check($sformatf("leftover outputs dut%0d", k), 32'(exp_q[k].size()), 32'd0);
         check($sformatf("leftover frame_done dut%0d", k), 32'(fd_q[k].size()), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
